// File: rtl/r3_pkg.sv
// ============================================================================
// r3_pkg : shared mod-3 coefficient encoding, lane adder and FSM state codes
// Rev 1.0
// ============================================================================
`default_nettype none

package r3_pkg;

   // Two-bit-plane coefficient codes, packed as {plane1, plane0}
   localparam logic [1:0] R3_ZERO = 2'b00;
   localparam logic [1:0] R3_ONE  = 2'b01;
   localparam logic [1:0] R3_TWO  = 2'b10;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   // Code (1,1) is non-canonical and reads as zero
   function automatic logic [1:0] r3_val(input logic [1:0] c);
      logic [1:0] v;
      case (c)
         R3_ONE:  v = 2'd1;
         R3_TWO:  v = 2'd2;
         default: v = 2'd0;
      endcase
      return v;
   endfunction

   function automatic logic [1:0] r3_add(input logic [1:0] a, input logic [1:0] b);
      logic [2:0] s;
      logic [1:0] r;
      s = {1'b0, r3_val(a)} + {1'b0, r3_val(b)};
      case (s)
         3'd1, 3'd4: r = R3_ONE;
         3'd2:       r = R3_TWO;
         default:    r = R3_ZERO;
      endcase
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/r3_add_vec.sv
// ============================================================================
// r3_add_vec : lane-wise mod-3 adder over two bit planes, canonical result
// Rev 1.0
// ============================================================================
`default_nettype none

module r3_add_vec
   import r3_pkg::*;
#(
   parameter int W = 64
) (
   input  logic [W-1:0] i_a_p0,
   input  logic [W-1:0] i_a_p1,
   input  logic [W-1:0] i_b_p0,
   input  logic [W-1:0] i_b_p1,
   output logic [W-1:0] o_s_p0,
   output logic [W-1:0] o_s_p1
);

   genvar g;
   generate
      for (g = 0; g < W; g++) begin : g_lane
         logic [1:0] w_s;
         assign w_s       = r3_add({i_a_p1[g], i_a_p0[g]}, {i_b_p1[g], i_b_p0[g]});
         assign o_s_p0[g] = w_s[0];
         assign o_s_p1[g] = w_s[1];
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/r3_prod_accum.sv
// ============================================================================
// r3_prod_accum : accumulates offset tile products mod 3, then drains words
// Rev 1.0
// ============================================================================
`default_nettype none

module r3_prod_accum
   import r3_pkg::*;
#(
   parameter int NBLK = 4,
   parameter int OFFW = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_last,
   input  logic [OFFW-1:0] in_off,
   input  logic [63:0]     DI_P0,
   input  logic [63:0]     DI_P1,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [OFFW:0]   out_idx,
   output logic [31:0]     DO_0,
   output logic [31:0]     DO_1,
   output logic            err
);

   localparam int c_NW   = 2 * NBLK;
   localparam int c_IDXW = OFFW + 1;

   logic [1:0]        r_state;
   logic [c_IDXW-1:0] r_idx;
   logic              r_err;
   logic [31:0]       r_acc0 [c_NW];
   logic [31:0]       r_acc1 [c_NW];

   logic [c_IDXW-1:0] w_lo;
   logic [c_IDXW-1:0] w_hi;
   logic              w_illegal;
   logic              w_accept;
   logic              w_wr;
   logic [31:0]       w_lo0, w_lo1, w_hi0, w_hi1;
   logic [31:0]       w_out0, w_out1;
   logic [63:0]       w_sum0, w_sum1;
   logic              w_unused_msb;

   assign w_lo      = {1'b0, in_off};
   assign w_hi      = w_lo + c_IDXW'(1);
   assign w_illegal = (w_lo > c_IDXW'(c_NW - 2));
   assign w_accept  = (r_state == ACCUM) && in_valid;
   assign w_wr      = w_accept && !w_illegal;

   // Bit 63 of each product plane carries no coefficient
   assign w_unused_msb = DI_P0[63] ^ DI_P1[63];

   always_comb begin
      w_lo0  = '0;
      w_lo1  = '0;
      w_hi0  = '0;
      w_hi1  = '0;
      w_out0 = '0;
      w_out1 = '0;
      for (int w = 0; w < c_NW; w++) begin
         if (w_lo == c_IDXW'(w)) begin
            w_lo0 = r_acc0[w];
            w_lo1 = r_acc1[w];
         end
         if (w_hi == c_IDXW'(w)) begin
            w_hi0 = r_acc0[w];
            w_hi1 = r_acc1[w];
         end
         if (r_idx == c_IDXW'(w)) begin
            w_out0 = r_acc0[w];
            w_out1 = r_acc1[w];
         end
      end
   end

   // Lane 63 adds zero, so the top bit of the upper word is written back unchanged
   r3_add_vec #(.W(64)) u_add (
      .i_a_p0 ({w_hi0, w_lo0}),
      .i_a_p1 ({w_hi1, w_lo1}),
      .i_b_p0 ({1'b0, DI_P0[62:0]}),
      .i_b_p1 ({1'b0, DI_P1[62:0]}),
      .o_s_p0 (w_sum0),
      .o_s_p1 (w_sum1)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_err   <= 1'b0;
         for (int w = 0; w < c_NW; w++) begin
            r_acc0[w] <= '0;
            r_acc1[w] <= '0;
         end
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state <= ACCUM;
                  r_idx   <= '0;
                  r_err   <= 1'b0;
                  for (int w = 0; w < c_NW; w++) begin
                     r_acc0[w] <= '0;
                     r_acc1[w] <= '0;
                  end
               end
            end
            ACCUM: begin
               if (w_accept) begin
                  if (w_illegal) r_err <= 1'b1;
                  for (int w = 0; w < c_NW; w++) begin
                     if (w_wr && (w_lo == c_IDXW'(w))) begin
                        r_acc0[w] <= w_sum0[31:0];
                        r_acc1[w] <= w_sum1[31:0];
                     end else if (w_wr && (w_hi == c_IDXW'(w))) begin
                        r_acc0[w] <= w_sum0[63:32];
                        r_acc1[w] <= w_sum1[63:32];
                     end
                  end
                  if (in_last) begin
                     r_state <= DRAIN;
                     r_idx   <= '0;
                  end
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  if (r_idx == c_IDXW'(c_NW - 1)) begin
                     r_state <= IDLE;
                     r_idx   <= '0;
                  end else begin
                     r_idx <= r_idx + c_IDXW'(1);
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == ACCUM);
   assign out_valid = (r_state == DRAIN);
   assign out_idx   = r_idx;
   assign DO_0      = (r_state == DRAIN) ? w_out0 : 32'd0;
   assign DO_1      = (r_state == DRAIN) ? w_out1 : 32'd0;
   assign err       = r_err;

endmodule

`default_nettype wire

// File: doc/r3_prod_accum.md
Name: r3_prod_accum

Overview:
- Downstream of the 32x32 R3 tile multiplier.
- Accepts a stream of 63-coefficient partial products in two-bit-plane encoding. Each product is tagged with a block offset. The block adds each product mod 3 into a register accumulator at coefficient position 32*offset.
- After the last product, drains the full (2*NBLK*32)-coefficient result as 32-coefficient words over a valid/ready handshake.
- Used to build NBLK*32-coefficient schoolbook products from tile products before the ring-reduction stage.

Parameters:
- NBLK, 4, operand length in 32-coefficient blocks; accumulator holds 2*NBLK words of 32 coefficients.
- OFFW, 3, width of in_off; must satisfy 2^OFFW >= 2*NBLK-1.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  pulse: clear accumulator and enter ACCUM
- in_valid  input  1  product word present
- in_ready  output  1  product accepted this cycle when in_valid&in_ready
- in_last  input  1  marks final product of the operation
- in_off  input  OFFW  block offset (i+j of tile indices), legal 0..2*NBLK-2
- DI_P0  input  64  product plane 0, bits 62:0 = coefficients 0..62, bit 63 ignored
- DI_P1  input  64  product plane 1, same layout
- out_valid  output  1  result word present
- out_ready  input  1  consumer accepts word
- out_idx  output  OFFW+1  index of current result word, 0..2*NBLK-1
- DO_0  output  32  result word plane 0
- DO_1  output  32  result word plane 1
- err  output  1  sticky: illegal in_off seen since last start

Behaviour:
- Coefficient encoding (b0,b1):
  - (0,0)=0, (1,0)=1, (0,1)=2.
  - (1,1) on input is treated as 0.
  - Outputs and the accumulator always hold canonical codes.
- Per-coefficient add mod 3 is combinational: acc <= r3_add(acc, p).
- States:
  - IDLE, ACCUM, DRAIN. Reset -> IDLE.
  - IDLE: in_ready=0, out_valid=0. start=1 -> clear accumulator and err -> ACCUM.
  - ACCUM: in_ready=1. On each accepted beat, coefficient k of the product (k=0..62) is added into accumulator coefficient 32*in_off+k. This spans words in_off and in_off+1, plus bit 30 of word in_off+2 does not exist: coefficient 62 maps to word in_off+1 bit 30. One product is absorbed per cycle, with no bubble between back-to-back beats. An accepted beat with in_last=1 -> DRAIN on the next cycle.
  - DRAIN: in_ready=0. out_valid=1 and out_idx counts from 0. DO_0/DO_1 show word out_idx. Each out_valid&out_ready advances out_idx. DO and out_idx are held stable while out_ready=0. Acceptance of word 2*NBLK-1 -> IDLE.
- Illegal offset: in_off > 2*NBLK-2 -> the beat is consumed but not accumulated, and err is set. If in_last is also set, the beat still moves the FSM to DRAIN.
- start outside IDLE: ignored in ACCUM and DRAIN; an operation cannot be aborted except by rst.
- in_valid in IDLE/DRAIN: not accepted; in_ready=0.
- Latency: last beat accepted at cycle t -> word 0 valid at t+1. With out_ready held high, drain takes 2*NBLK cycles.
- Reset values: in_ready=0, out_valid=0, out_idx=0, DO_0=DO_1=0, err=0, accumulator=0. rst mid-ACCUM or mid-DRAIN discards all state and returns to IDLE.
- The top word's final bit (coefficient 2*NBLK*32-1) is always 0 for legal input.

Decomposition:
- Shared package r3_pkg holds:
  - the encoding constants R3_ZERO/R3_ONE/R3_TWO;
  - function r3_add (2-bit x 2-bit -> canonical 2-bit);
  - state encodings IDLE/ACCUM/DRAIN.
- One natural sub-module: r3_add_vec, a parameterised-width lane-wise mod-3 adder over the two bit planes. It is instantiated once, 64 lanes wide, and its result is written back to the two target words.

Test Plan:
- Single unit product: start; in_off=0, DI_P0=1, DI_P1=0, in_last=1 -> word0 DO_0=0x00000001, DO_1=0; all other words 0; err=0.
- Mod-3 wrap:
  - two beats at in_off=0, DI_P0=1 -> word0 DO_0=0, DO_1=1.
  - a third identical beat -> word0 DO_0=0, DO_1=0.
- Cross-word placement: in_off=1, DI_P0 bit62=1 and bit0=1 -> word1 DO_0=0x00000001, word2 DO_0=0x40000000.
- Illegal offset: in_off=7 with NBLK=4, DI_P0=all ones, in_last=1 -> err=1, all 8 output words zero, FSM reaches DRAIN and returns to IDLE.
- Backpressure: out_ready low for 5 cycles at out_idx=3 -> out_valid, out_idx=3 and DO held; release -> words 3..7 on consecutive cycles, then IDLE.
- Reset mid-DRAIN: rst at out_idx=2 -> next cycle out_valid=0, err=0. A new start with no products plus in_last on a zero beat -> all words 0.
